// File: rtl/musa_pkg.sv
// Shared MUSA decode definitions: opcodes, ALU encodings and the control bundle
// produced by the opcode decoder.
package musa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_FUNC = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2
  } dst_sel_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t    ctrl;
    dst_sel_e dst_sel;
    logic     uses_rt;
    logic     zero_ext;
  } decode_t;

  // Unknown opcodes fall through as an all-zero control bundle (NOP).
  function automatic decode_t decode_op(input logic [5:0] opcode);
    decode_t d;
    d = '0;
    case (opcode)
      OP_RTYPE: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = ALU_FUNC;
        d.dst_sel        = DST_RD;
        d.uses_rt        = 1'b1;
      end
      OP_LW: begin
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.alu_op     = ALU_ADD;
        d.dst_sel         = DST_RT;
      end
      OP_SW: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_op    = ALU_ADD;
        d.uses_rt        = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_op    = ALU_ADD;
        d.dst_sel        = DST_RT;
      end
      OP_ANDI, OP_ORI: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        d.dst_sel        = DST_RT;
        d.zero_ext       = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.branch = 1'b1;
        d.ctrl.alu_op = ALU_SUB;
        d.uses_rt     = 1'b1;
      end
      OP_J: begin
        d.ctrl.jump = 1'b1;
      end
      default: begin
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with r0 hard-wired to zero and write-first bypass on both read ports.
module regfile_bypass #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data
);

  localparam int unsigned DEPTH = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // A write landing this cycle is returned to the reader instead of the stale entry.
  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (wb_en && (wb_addr == rs_addr)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (wb_en && (wb_addr == rt_addr)) begin
      rt_data = wb_data;
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// MUSA instruction-decode stage: control decode, operand fetch and the ID/EX
// register with back-pressure, flush and load-use stall insertion.
module decode_stage_pipe
  import musa_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_rs_data,
  output logic [DATA_W-1:0]     out_rt_data,
  output logic [DATA_W-1:0]     out_imm,
  output logic [REG_ADDR_W-1:0] out_rs,
  output logic [REG_ADDR_W-1:0] out_rt,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic [2:0]            out_alu_op,
  output logic [5:0]            out_func,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic                  out_alu_src,
  output logic                  out_branch,
  output logic                  out_jump,
  output logic [DATA_W-1:0]     out_jump_target
);

  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] dst;
  logic [DATA_W-1:0]     imm_ext;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  decode_t               dec;
  ctrl_t                 ex_ctrl;
  logic                  hazard;
  logic                  transfer;

  assign rs  = REG_ADDR_W'(instruction[25:21]);
  assign rt  = REG_ADDR_W'(instruction[20:16]);
  assign rd  = REG_ADDR_W'(instruction[15:11]);
  assign dec = decode_op(instruction[31:26]);

  always_comb begin
    imm_ext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    if (dec.zero_ext) begin
      imm_ext = {{(DATA_W-16){1'b0}}, instruction[15:0]};
    end
  end

  always_comb begin
    dst = '0;
    case (dec.dst_sel)
      DST_RD:  dst = rd;
      DST_RT:  dst = rt;
      default: dst = '0;
    endcase
  end

  regfile_bypass #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  // A load still in ID/EX cannot forward its result; hold the consumer for one cycle.
  assign hazard = out_valid && out_mem_read && (out_dst != '0) &&
                  ((rs == out_dst) || (dec.uses_rt && (rt == out_dst)));
  assign if_ready = (!out_valid || ex_ready) && !hazard;
  assign transfer = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      ex_ctrl         <= '0;
      out_rs_data     <= '0;
      out_rt_data     <= '0;
      out_imm         <= '0;
      out_rs          <= '0;
      out_rt          <= '0;
      out_dst         <= '0;
      out_func        <= '0;
      out_jump_target <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid       <= 1'b1;
      ex_ctrl         <= dec.ctrl;
      out_rs_data     <= rs_data;
      out_rt_data     <= rt_data;
      out_imm         <= imm_ext;
      out_rs          <= rs;
      out_rt          <= rt;
      out_dst         <= dst;
      out_func        <= instruction[5:0];
      out_jump_target <= DATA_W'({instruction[25:0], 2'b00});
    end else if (ex_ready && (hazard || !if_valid)) begin
      out_valid <= 1'b0;
    end
  end

  assign out_mem_read   = ex_ctrl.mem_read;
  assign out_mem_write  = ex_ctrl.mem_write;
  assign out_reg_write  = ex_ctrl.reg_write;
  assign out_mem_to_reg = ex_ctrl.mem_to_reg;
  assign out_alu_src    = ex_ctrl.alu_src;
  assign out_branch     = ex_ctrl.branch;
  assign out_jump       = ex_ctrl.jump;
  assign out_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomised and directed bench for decode_stage_pipe against a cycle-level
// behavioural model of the decode rules.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        if_valid;
  logic        if_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        out_valid;
  logic [31:0] out_rs_data, out_rt_data, out_imm, out_jump_target;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic [2:0]  out_alu_op;
  logic [5:0]  out_func;
  logic        out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg;
  logic        out_alu_src, out_branch, out_jump;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .if_valid(if_valid),
    .if_ready(if_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_ready(ex_ready), .out_valid(out_valid),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst), .out_alu_op(out_alu_op),
    .out_func(out_func), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .out_alu_src(out_alu_src), .out_branch(out_branch), .out_jump(out_jump),
    .out_jump_target(out_jump_target)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm, jt;
    logic [4:0]  rs, rt, dst;
    logic [2:0]  alu_op;
    logic [5:0]  func;
    logic        mr, mw, rw, m2r, asrc, br, jmp;
  } exp_t;

  exp_t        mdl;
  logic [31:0] mregs [32];
  logic        armed = 1'b0;
  logic        accepted;
  int          acc_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && (wb_addr == a)) return wb_data;
    return mregs[a];
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
  endfunction

  function automatic exp_t mdecode(input logic [31:0] ins);
    exp_t        e;
    logic [5:0]  op;
    logic [15:0] imm;
    e   = '0;
    op  = ins[31:26];
    imm = ins[15:0];
    e.valid   = 1'b1;
    e.rs      = ins[25:21];
    e.rt      = ins[20:16];
    e.func    = ins[5:0];
    e.rs_data = mread(e.rs);
    e.rt_data = mread(e.rt);
    e.imm     = {{16{imm[15]}}, imm};
    e.jt      = {4'b0, ins[25:0], 2'b00};
    case (op)
      6'h00: begin e.rw = 1'b1; e.dst = ins[15:11]; e.alu_op = 3'd2; end
      6'h23: begin e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; e.asrc = 1'b1; e.dst = e.rt; end
      6'h2B: begin e.mw = 1'b1; e.asrc = 1'b1; end
      6'h08: begin e.rw = 1'b1; e.asrc = 1'b1; e.dst = e.rt; end
      6'h0C, 6'h0D: begin
        e.rw = 1'b1; e.asrc = 1'b1; e.dst = e.rt;
        e.alu_op = (op == 6'h0C) ? 3'd3 : 3'd4;
        e.imm = {16'h0, imm};
      end
      6'h04: begin e.br = 1'b1; e.alu_op = 3'd1; end
      6'h02: e.jmp = 1'b1;
      default: begin end
    endcase
    return e;
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(mdl.valid));
    if (mdl.valid) begin
      check("rs_data", out_rs_data, mdl.rs_data);
      check("rt_data", out_rt_data, mdl.rt_data);
      check("imm", out_imm, mdl.imm);
      check("jump_target", out_jump_target, mdl.jt);
      check("rs", 32'(out_rs), 32'(mdl.rs));
      check("rt", 32'(out_rt), 32'(mdl.rt));
      check("alu_op", 32'(out_alu_op), 32'(mdl.alu_op));
      check("func", 32'(out_func), 32'(mdl.func));
      check("ctrl", 32'({out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
                         out_alu_src, out_branch, out_jump}),
                    32'({mdl.mr, mdl.mw, mdl.rw, mdl.m2r, mdl.asrc, mdl.br, mdl.jmp}));
      if (mdl.rw) check("dst", 32'(out_dst), 32'(mdl.dst));
    end
  endtask

  // One clock: inputs were set after the previous falling edge.
  task automatic cycle();
    logic hz, rdy;
    #1;
    hz = mdl.valid && mdl.mr && (mdl.dst != 5'd0) &&
         ((instruction[25:21] == mdl.dst) ||
          (uses_rt(instruction[31:26]) && (instruction[20:16] == mdl.dst)));
    rdy = (!mdl.valid || ex_ready) && !hz;
    if (armed) check("if_ready", 32'(if_ready), 32'(rdy));
    accepted = 1'b0;
    @(posedge clk);
    if (rst) begin
      mdl = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      armed = 1'b1;
    end else begin
      if (flush) mdl.valid = 1'b0;
      else if (if_valid && rdy) begin
        mdl = mdecode(instruction);
        accepted = 1'b1;
        acc_cnt++;
      end else if (ex_ready && (hz || !if_valid)) mdl.valid = 1'b0;
      if (wb_en && (wb_addr != 5'd0)) mregs[wb_addr] = wb_data;
    end
    #1;
    if (armed) check_outputs();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, output int n);
    instruction = ins;
    if_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && (n < 20));
    if (!accepted) check("issue_timeout", 32'd0, 32'd1);
    if_valid = 1'b0;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 8))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2B;
      3: op = 6'h08;
      4: op = 6'h0C;
      5: op = 6'h0D;
      6: op = 6'h04;
      7: op = 6'h02;
      default: op = 6'h3F;
    endcase
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 11'($urandom)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    rst = 1'b1; instruction = 32'd0; if_valid = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; ex_ready = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd1);
    check("rst_data", out_rs_data | out_rt_data | out_imm | out_jump_target, 32'd0);
    check("rst_ctrl", 32'({out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
                           out_alu_src, out_branch, out_jump, out_alu_op, out_func,
                           out_rs, out_rt, out_dst}), 32'd0);

    for (int k = 0; k < 16; k++) issue(rtype(5'(2 * k), 5'(2 * k + 1), 5'd1, 6'h20), n);

    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    cycle();
    wb_en = 1'b0;
    issue(rtype(5'd5, 5'd0, 5'd1, 6'h20), n);
    check("wr_rd_rs", out_rs_data, 32'h1234);
    check("wr_rd_rt", out_rt_data, 32'h0);
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hABCD;
    issue(rtype(5'd6, 5'd0, 5'd1, 6'h20), n);
    wb_en = 1'b0;
    check("bypass_rs", out_rs_data, 32'hABCD);

    issue(itype(6'h08, 5'd0, 5'd1, 16'hFFF0), n);
    check("addi_imm", out_imm, 32'hFFFF_FFF0);
    issue(itype(6'h0D, 5'd0, 5'd1, 16'hFFF0), n);
    check("ori_imm", out_imm, 32'h0000_FFF0);
    check("ori_alu_op", 32'(out_alu_op), 32'd4);

    issue(itype(6'h23, 5'd1, 5'd3, 16'h0), n);
    issue(rtype(5'd3, 5'd2, 5'd4, 6'h20), n);
    check("loaduse_cycles", 32'(n), 32'd2);
    check("loaduse_rs", 32'(out_rs), 32'd3);
    issue(itype(6'h23, 5'd1, 5'd3, 16'h0), n);
    issue(rtype(5'd2, 5'd2, 5'd4, 6'h20), n);
    check("nohazard_cycles", 32'(n), 32'd1);

    issue(rtype(5'd1, 5'd2, 5'd8, 6'h20), n);
    ex_ready = 1'b0;
    instruction = rtype(5'd3, 5'd4, 5'd9, 6'h22);
    if_valid = 1'b1;
    acc0 = acc_cnt;
    repeat (3) cycle();
    check("bp_hold_dst", 32'(out_dst), 32'd8);
    check("bp_if_ready", 32'(if_ready), 32'd0);
    ex_ready = 1'b1;
    cycle();
    if_valid = 1'b0;
    check("bp_accepted_once", 32'(acc_cnt - acc0), 32'd1);
    check("bp_next_dst", 32'(out_dst), 32'd9);
    cycle();
    check("bp_bubble", 32'(out_valid), 32'd0);

    ex_ready = 1'b0;
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), n);
    instruction = rtype(5'd4, 5'd5, 5'd6, 6'h20);
    if_valid = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    check("rst_stall_ready", 32'(if_ready), 32'd1);
    if_valid = 1'b0;
    ex_ready = 1'b1;

    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), n);
    flush = 1'b1; if_valid = 1'b1; instruction = rtype(5'd7, 5'd0, 5'd2, 6'h20);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd9;
    cycle();
    flush = 1'b0; if_valid = 1'b0; wb_en = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_dropped", 32'(accepted), 32'd0);
    issue(rtype(5'd7, 5'd0, 5'd2, 6'h20), n);
    check("flush_wb_r7", out_rs_data, 32'd9);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd5;
    issue(rtype(5'd0, 5'd0, 5'd2, 6'h20), n);
    wb_en = 1'b0;
    check("r0_bypass", out_rs_data, 32'd0);
    issue(rtype(5'd0, 5'd7, 5'd2, 6'h20), n);
    check("r0_read", out_rs_data, 32'd0);
    check("r7_rt", out_rt_data, 32'd9);

    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      instruction = rand_instr();
      if_valid    = ($urandom_range(0, 9) < 8);
      ex_ready    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      wb_en       = ($urandom_range(0, 9) < 4);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
